// File: rtl/alu.sv
// alu: registered 32-bit execute-stage ALU (arith/logic, shifts, address generation)
// Ports: clock, reset (async active-low); aluin1/aluin2 operands; operation sub-op;
// opselect class; shift_number amount; enable_arith/enable_shift class qualifiers;
// aluout/carryout registered result and carry/borrow.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] aluin1,
  input  logic [WIDTH-1:0] aluin2,
  input  logic [2:0]       operation,
  input  logic [2:0]       opselect,
  input  logic [4:0]       shift_number,
  input  logic             enable_arith,
  input  logic             enable_shift,
  output logic [WIDTH-1:0] aluout,
  output logic             carryout
);
  logic [WIDTH-1:0] aluout_d, aluout_q;
  logic             carry_d, carry_q;
  logic [WIDTH:0]   sum, diff;
  logic [16:0]      hsum;
  logic             do_arith, do_mem, do_shift;
  assign sum      = {1'b0, aluin1} + {1'b0, aluin2};
  // top bit of the zero-extended difference is the unsigned borrow
  assign diff     = {1'b0, aluin1} - {1'b0, aluin2};
  assign hsum     = {1'b0, aluin1[15:0]} + {1'b0, aluin2[15:0]};
  assign do_arith = enable_arith && opselect == 3'b001;
  assign do_mem   = enable_arith && (opselect == 3'b100 || opselect == 3'b101);
  assign do_shift = enable_shift && opselect == 3'b000 && !operation[2];
  always_comb begin
    aluout_d = aluout_q;
    carry_d  = carry_q;
    if (do_arith) begin
      carry_d = 1'b0;
      case (operation)
        3'b000: {carry_d, aluout_d} = sum;
        3'b001: {carry_d, aluout_d} = {hsum[16], {(WIDTH-16){hsum[15]}}, hsum[15:0]};
        3'b010: {carry_d, aluout_d} = diff;
        3'b011: aluout_d = ~aluin2;
        3'b100: aluout_d = aluin1 & aluin2;
        3'b101: aluout_d = aluin1 | aluin2;
        3'b110: aluout_d = aluin1 ^ aluin2;
        default: aluout_d = {aluin2[15:0], {(WIDTH-16){1'b0}}};
      endcase
    end else if (do_mem) begin
      aluout_d = sum[WIDTH-1:0];
      carry_d  = 1'b0;
    end else if (do_shift) begin
      carry_d  = 1'b0;
      aluout_d = !operation[1] ? aluin1 << shift_number
               : !operation[0] ? aluin1 >> shift_number
               : WIDTH'($signed(aluin1) >>> shift_number);
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      aluout_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      aluout_q <= aluout_d;
      carry_q  <= carry_d;
    end
  assign aluout   = aluout_q;
  assign carryout = carry_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: table-driven scoreboard bench for alu
module tb_alu;
  logic        clock = 0, reset = 0;
  logic [31:0] aluin1 = 0, aluin2 = 0, aluout;
  logic [2:0]  operation = 0, opselect = 0;
  logic [4:0]  shift_number = 0;
  logic        enable_arith = 0, enable_shift = 0, carryout;
  int          n_chk = 0, n_fail = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [2:0]  opsel, op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        ea, es;
    logic [31:0] out;
    logic        c;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clock(clock), .reset(reset), .aluin1(aluin1), .aluin2(aluin2),
    .operation(operation), .opselect(opselect), .shift_number(shift_number),
    .enable_arith(enable_arith), .enable_shift(enable_shift),
    .aluout(aluout), .carryout(carryout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [32:0] exp);
    n_chk++;
    if ({carryout, aluout} !== exp) begin
      n_fail++;
      $display("FAIL %s: got carry=%0b out=%h, expected carry=%0b out=%h",
               name, carryout, aluout, exp[32], exp[31:0]);
    end
  endtask

  task automatic drive(input vec_t v);
    opselect = v.opsel; operation = v.op; aluin1 = v.a; aluin2 = v.b;
    shift_number = v.sh; enable_arith = v.ea; enable_shift = v.es;
  endtask

  task automatic add(input logic [2:0] opsel, op, input logic [31:0] a, b,
                     input logic [4:0] sh, input logic ea, es,
                     input logic [31:0] out, input logic c);
    vec_t v;
    v.opsel = opsel; v.op = op; v.a = a; v.b = b; v.sh = sh;
    v.ea = ea; v.es = es; v.out = out; v.c = c;
    vecs.push_back(v);
  endtask

  initial begin
    // ARITH_LOGIC
    add(3'b001, 3'b000, 32'hFFFF_FFFF, 32'h1, 0, 1, 0, 32'h0, 1);
    add(3'b001, 3'b000, 32'd5, -32'sd3, 0, 1, 0, 32'd2, 1);
    add(3'b001, 3'b010, 32'd3, 32'd5, 0, 1, 0, 32'hFFFF_FFFE, 1);
    add(3'b001, 3'b010, 32'd5, 32'd3, 0, 1, 0, 32'd2, 0);
    add(3'b001, 3'b001, 32'h0000_7FFF, 32'h1, 0, 1, 0, 32'hFFFF_8000, 0);
    add(3'b001, 3'b001, 32'h1234_FFFF, 32'h1, 0, 1, 0, 32'h0, 1);
    add(3'b001, 3'b111, 32'h5555_5555, 32'h1234_ABCD, 0, 1, 0, 32'hABCD_0000, 0);
    add(3'b001, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1, 0, 32'h00F0_00F0, 0);
    add(3'b001, 3'b101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1, 0, 32'hFFF0_FFF0, 0);
    add(3'b001, 3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1, 0, 32'hFF00_FF00, 0);
    add(3'b001, 3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1, 0, 32'hF00F_F00F, 0);
    // SHIFT_REG
    add(3'b000, 3'b000, 32'h8000_0010, 0, 4, 0, 1, 32'h0000_0100, 0);
    add(3'b000, 3'b001, 32'h8000_0010, 0, 4, 0, 1, 32'h0000_0100, 0);
    add(3'b000, 3'b010, 32'h8000_0010, 0, 4, 0, 1, 32'h0800_0001, 0);
    add(3'b000, 3'b011, 32'h8000_0010, 0, 4, 0, 1, 32'hF800_0001, 0);
    add(3'b000, 3'b011, 32'h8000_0010, 0, 0, 0, 1, 32'h8000_0010, 0);
    add(3'b000, 3'b011, 32'h8000_0010, 0, 31, 0, 1, 32'hFFFF_FFFF, 0);
    add(3'b000, 3'b010, 32'h8000_0010, 0, 31, 0, 1, 32'h0000_0001, 0);
    add(3'b000, 3'b100, 32'h1234_5678, 0, 4, 1, 1, 32'h0000_0001, 0);
    add(3'b000, 3'b000, 32'h1, 0, 3, 1, 1, 32'h8, 0);
    // gating / hold
    add(3'b001, 3'b000, 32'd3, 32'd4, 0, 1, 0, 32'd7, 0);
    add(3'b000, 3'b000, 32'hFFFF, 0, 4, 1, 0, 32'd7, 0);
    add(3'b110, 3'b000, 32'd1, 32'd1, 0, 1, 1, 32'd7, 0);
    add(3'b001, 3'b000, 32'd1, 32'd1, 0, 0, 1, 32'd7, 0);
    add(3'b101, 3'b000, 32'd1, 32'd1, 0, 0, 0, 32'd7, 0);
    add(3'b101, 3'b011, 32'd100, -32'sd4, 0, 1, 0, 32'd96, 0);
    add(3'b100, 3'b010, 32'd10, 32'd20, 0, 1, 1, 32'd30, 0);
    add(3'b001, 3'b000, 32'hFFFF_FFFF, 32'h1, 0, 1, 0, 32'h0, 1);
    add(3'b010, 3'b000, 32'd9, 32'd9, 0, 1, 1, 32'h0, 1);
    add(3'b000, 3'b110, 32'd9, 32'd9, 1, 1, 1, 32'h0, 1);
    add(3'b111, 3'b000, 32'd9, 32'd9, 0, 1, 1, 32'h0, 1);

    // reset held low with random stimulus and both enables high
    enable_arith = 1; enable_shift = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      aluin1 = $urandom; aluin2 = $urandom;
      operation = 3'($urandom); opselect = 3'($urandom_range(0, 1));
      shift_number = 5'($urandom);
      @(posedge clock); #1;
      chk("reset_hold", 33'h0);
    end
    // release: no update until the following edge
    @(negedge clock);
    reset = 1;
    opselect = 3'b001; operation = 3'b000; aluin1 = 32'd1; aluin2 = 32'd1;
    #1 chk("release_no_update", 33'h0);
    @(posedge clock); #1;
    chk("release_first_edge", {1'b0, 32'd2});

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      exp_q.push_back({vecs[i].c, vecs[i].out});
      @(posedge clock); #1;
      chk($sformatf("vec%0d", i), exp_q.pop_front());
    end

    // asynchronous reset mid-cycle clears at once and discards the pending result
    @(negedge clock);
    opselect = 3'b001; operation = 3'b000; aluin1 = 32'd10; aluin2 = 32'd20;
    enable_arith = 1;
    #2 reset = 0;
    #1 chk("async_reset", 33'h0);
    @(posedge clock); #1;
    chk("reset_discard", 33'h0);
    @(negedge clock);
    reset = 1; enable_arith = 0; enable_shift = 0;
    @(posedge clock); #1;
    chk("post_reset_hold", 33'h0);

    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
